rb_param: RTL and testbench

- Parametrised successor register bank for the datapath.
- Holds general-purpose, input-port, output-port, auxiliary and working registers.
- Serves two operand read ports (A, B) and one result write port (bus C).
- Performs handshaked memory load/store through the working register, with an explicit wait-state FSM and same-cycle write forwarding to the operand ports.

---
 rtl/rb_param_if.sv | 34 +++
 rtl/rb_param.sv | 136 +++++++++++++
 tb/tb_rb_param.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rb_param_if.sv
// Bundles the operand, result and memory-handshake signals of the rb_param register bank.
// Clock and reset are kept outside the interface.
interface rb_param_if #(
  parameter int DW   = 16,
  parameter int AW   = 6,
  parameter int NIN  = 2,
  parameter int NOUT = 2
);
  logic [1:0]         MC;
  logic [AW-1:0]      WRC;
  logic [AW-1:0]      busA;
  logic [AW-1:0]      busB;
  logic [DW-1:0]      busC;
  logic [DW-1:0]      Mdata;
  logic               mem_ready;
  logic [NIN*DW-1:0]  in_port;
  logic [DW-1:0]      A;
  logic [DW-1:0]      B;
  logic [DW-1:0]      WRdata;
  logic               mem_req;
  logic               mem_we;
  logic               busy;
  logic [NOUT*DW-1:0] out_port;

  modport master (
    output MC, WRC, busA, busB, busC, Mdata, mem_ready, in_port,
    input  A, B, WRdata, mem_req, mem_we, busy, out_port
  );

  modport slave (
    input  MC, WRC, busA, busB, busC, Mdata, mem_ready, in_port,
    output A, B, WRdata, mem_req, mem_we, busy, out_port
  );
endinterface

// File: rtl/rb_param.sv
// Parametrised register bank: two forwarded operand read ports, one bus C write port,
// live input/output port registers and a wait-state FSM for loads/stores via the working register.
module rb_param #(
  parameter int DW       = 16,
  parameter int NREG     = 35,
  parameter int AW       = 6,
  parameter int IN_BASE  = 28,
  parameter int NIN      = 2,
  parameter int OUT_BASE = 30,
  parameter int NOUT     = 2,
  parameter int WR_IDX   = 34
) (
  input  logic        clk,
  input  logic        rst,
  rb_param_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [AW-1:0] NREG_A  = AW'(NREG);
  localparam logic [AW-1:0] IN_LO_A = AW'(IN_BASE);
  localparam logic [AW-1:0] IN_HI_A = AW'(IN_BASE + NIN);
  localparam logic [AW-1:0] WR_A    = AW'(WR_IDX);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  state_t        state_q, state_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;

  logic          c_wr_en;
  logic [DW-1:0] wr_fwd;

  // Writes to input-port registers or out-of-range indices are silently dropped.
  assign c_wr_en = (bus.WRC < NREG_A) && !((bus.WRC >= IN_LO_A) && (bus.WRC < IN_HI_A));
  assign wr_fwd  = (c_wr_en && (bus.WRC == WR_A)) ? bus.busC : regs_q[WR_IDX];

  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    wrdata_d  = wrdata_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;

    if (c_wr_en) begin
      regs_d[bus.WRC] = bus.busC;
    end
    for (int i = 0; i < NIN; i++) begin
      regs_d[IN_BASE + i] = bus.in_port[i*DW +: DW];
    end

    case (state_q)
      IDLE: begin
        // MC=11 is illegal and falls through as a no-op.
        if (bus.MC == 2'b10) begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          state_d   = RD_WAIT;
        end else if (bus.MC == 2'b01) begin
          wrdata_d  = wr_fwd;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          state_d   = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.mem_ready) begin
          // Placed after the bus C write so memory wins a same-edge conflict.
          regs_d[WR_IDX] = bus.Mdata;
          mem_req_d      = 1'b0;
          state_d        = IDLE;
        end
      end
      WR_WAIT: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      state_q   <= IDLE;
      wrdata_q  <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      state_q   <= state_d;
      wrdata_q  <= wrdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  // Operand reads see a pending bus C write in the same cycle.
  always_comb begin
    if (c_wr_en && (bus.busA == bus.WRC)) begin
      bus.A = bus.busC;
    end else if (bus.busA < NREG_A) begin
      bus.A = regs_q[bus.busA];
    end else begin
      bus.A = '0;
    end
  end

  always_comb begin
    if (c_wr_en && (bus.busB == bus.WRC)) begin
      bus.B = bus.busC;
    end else if (bus.busB < NREG_A) begin
      bus.B = regs_q[bus.busB];
    end else begin
      bus.B = '0;
    end
  end

  assign bus.WRdata  = wrdata_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.busy    = (state_q != IDLE);

  generate
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
      assign bus.out_port[gi*DW +: DW] = regs_q[OUT_BASE + gi];
    end
  endgenerate

endmodule

// File: tb/tb_rb_param.sv
// Randomised and directed checks of rb_param against a behavioural register-bank model.
module tb_rb_param;
  localparam int DW = 16, NREG = 35, AW = 6, IN_BASE = 28, NIN = 2;
  localparam int OUT_BASE = 30, NOUT = 2, WR_IDX = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rb_param_if #(.DW(DW), .AW(AW), .NIN(NIN), .NOUT(NOUT)) bus ();

  rb_param #(
    .DW(DW), .NREG(NREG), .AW(AW), .IN_BASE(IN_BASE), .NIN(NIN),
    .OUT_BASE(OUT_BASE), .NOUT(NOUT), .WR_IDX(WR_IDX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state: register contents plus the outstanding memory operation.
  logic [DW-1:0] m_regs [NREG];
  int            m_pending;   // 0 none, 1 load outstanding, 2 store outstanding
  logic [DW-1:0] m_wrdata;
  logic          m_req;
  logic          m_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writable(input int k);
    return (k < NREG) && !((k >= IN_BASE) && (k < IN_BASE + NIN));
  endfunction

  function automatic logic [DW-1:0] exp_read(input int idx);
    if (idx >= NREG) return '0;
    if (writable(int'(bus.WRC)) && idx == int'(bus.WRC)) return bus.busC;
    return m_regs[idx];
  endfunction

  task automatic model_check();
    logic [NOUT*DW-1:0] exp_out;
    for (int i = 0; i < NOUT; i++) exp_out[i*DW +: DW] = m_regs[OUT_BASE + i];
    chk("A", 64'(bus.A), 64'(exp_read(int'(bus.busA))));
    chk("B", 64'(bus.B), 64'(exp_read(int'(bus.busB))));
    chk("busy", 64'(bus.busy), 64'(m_pending != 0));
    chk("mem_req", 64'(bus.mem_req), 64'(m_req));
    chk("mem_we", 64'(bus.mem_we), 64'(m_we));
    chk("WRdata", 64'(bus.WRdata), 64'(m_wrdata));
    chk("out_port", 64'(bus.out_port), 64'(exp_out));
  endtask

  task automatic model_update();
    logic [DW-1:0] nxt [NREG];
    logic [DW-1:0] wr_now;
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_pending = 0; m_wrdata = '0; m_req = 1'b0; m_we = 1'b0;
      return;
    end
    nxt = m_regs;
    wr_now = exp_read(WR_IDX);
    if (writable(int'(bus.WRC))) nxt[int'(bus.WRC)] = bus.busC;
    for (int i = 0; i < NIN; i++) nxt[IN_BASE + i] = bus.in_port[i*DW +: DW];
    if (m_pending == 0) begin
      if (bus.MC == 2'b10) begin
        m_pending = 1; m_req = 1'b1; m_we = 1'b0;
      end else if (bus.MC == 2'b01) begin
        m_pending = 2; m_req = 1'b1; m_we = 1'b1; m_wrdata = wr_now;
      end
    end else if (bus.mem_ready) begin
      if (m_pending == 1) begin
        nxt[WR_IDX] = bus.Mdata;
        $display("[TB] load complete data=%04h", bus.Mdata);
      end else begin
        m_we = 1'b0;
        $display("[TB] store complete data=%04h", m_wrdata);
      end
      m_pending = 0; m_req = 1'b0;
    end
    m_regs = nxt;
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.MC = 2'b00; bus.WRC = 6'd63; bus.busA = '0; bus.busB = '0;
    bus.busC = '0; bus.Mdata = '0; bus.mem_ready = 1'b0; bus.in_port = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    edge_step();
    edge_step();
    rst = 1'b0;

    // Reset state
    settle();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_req", 64'(bus.mem_req), 64'd0);
    chk("rst_wrdata", 64'(bus.WRdata), 64'd0);
    chk("rst_out", 64'(bus.out_port), 64'd0);
    edge_step();

    // Plain write then read, plus out-of-range read
    bus.WRC = 6'd5; bus.busC = 16'hBEEF;
    settle(); edge_step();
    bus.WRC = 6'd63; bus.busA = 6'd5; bus.busB = 6'd40;
    settle();
    chk("rd5", 64'(bus.A), 64'h BEEF);
    chk("rd40", 64'(bus.B), 64'h0);
    edge_step();

    // Same-cycle forwarding
    bus.WRC = 6'd7; bus.busC = 16'h1234; bus.busA = 6'd7;
    settle();
    chk("fwd7", 64'(bus.A), 64'h1234);
    edge_step();

    // Load with three wait states and a colliding bus C write on the ack edge
    bus.WRC = 6'd63; bus.MC = 2'b10;
    settle(); edge_step();
    bus.MC = 2'b00;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ld_req", 64'(bus.mem_req), 64'd1);
      chk("ld_busy", 64'(bus.busy), 64'd1);
      edge_step();
    end
    bus.mem_ready = 1'b1; bus.Mdata = 16'hA5A5; bus.WRC = 6'd34; bus.busC = 16'h0001;
    settle();
    chk("ld_req4", 64'(bus.mem_req), 64'd1);
    edge_step();
    bus.mem_ready = 1'b0; bus.WRC = 6'd63; bus.busA = 6'd34;
    settle();
    chk("ld_wr", 64'(bus.A), 64'hA5A5);
    chk("ld_done", 64'(bus.mem_req), 64'd0);
    edge_step();

    // Store, with a load request issued while busy
    bus.WRC = 6'd34; bus.busC = 16'h00FF;
    settle(); edge_step();
    bus.WRC = 6'd63; bus.MC = 2'b01;
    settle(); edge_step();
    bus.MC = 2'b10;
    settle();
    chk("st_data", 64'(bus.WRdata), 64'h00FF);
    chk("st_req", 64'(bus.mem_req), 64'd1);
    chk("st_we", 64'(bus.mem_we), 64'd1);
    edge_step();
    bus.MC = 2'b00; bus.mem_ready = 1'b1;
    settle(); edge_step();
    bus.mem_ready = 1'b0;
    settle();
    chk("st_end_req", 64'(bus.mem_req), 64'd0);
    chk("st_end_busy", 64'(bus.busy), 64'd0);
    chk("st_hold", 64'(bus.WRdata), 64'h00FF);
    edge_step();
    settle();
    chk("no_second_req", 64'(bus.mem_req), 64'd0);
    edge_step();

    // Input port protection and output port update
    bus.in_port = 32'h0000_0042; bus.WRC = 6'd28; bus.busC = 16'hFFFF;
    settle(); edge_step();
    bus.WRC = 6'd31; bus.busC = 16'h0C0C; bus.busA = 6'd28;
    settle();
    chk("in28", 64'(bus.A), 64'h0042);
    edge_step();
    bus.WRC = 6'd63;
    settle();
    chk("out1", 64'(bus.out_port[31:16]), 64'h0C0C);
    edge_step();

    // Reset during a load; late ack ignored
    bus.MC = 2'b10;
    settle(); edge_step();
    bus.MC = 2'b00;
    settle(); edge_step();
    rst = 1'b1;
    settle(); edge_step();
    rst = 1'b0; bus.busA = 6'd34; bus.mem_ready = 1'b1; bus.Mdata = 16'h9999;
    settle();
    chk("rst_ld_req", 64'(bus.mem_req), 64'd0);
    chk("rst_ld_busy", 64'(bus.busy), 64'd0);
    chk("rst_wr0", 64'(bus.A), 64'd0);
    edge_step();
    bus.mem_ready = 1'b0;
    settle();
    chk("rst_wr_stays0", 64'(bus.A), 64'd0);
    edge_step();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.MC        = 2'($urandom_range(0, 3));
      bus.WRC       = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(26, 36)) : 6'($urandom_range(0, 63));
      bus.busA      = ($urandom_range(0, 1) == 0) ? bus.WRC : 6'($urandom_range(0, 40));
      bus.busB      = 6'($urandom_range(0, 63));
      bus.busC      = 16'($urandom);
      bus.Mdata     = 16'($urandom);
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      bus.in_port   = 32'($urandom);
      settle();
      edge_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
